// File: rtl/pkt_rx_pkg.sv
// pkt_rx_pkg: shared definitions for the receive-side packet checker.
//   state_t     : checker FSM states (IDLE = 0, BUSY = 1)
//   ERR_*       : bit positions inside the 4-bit err_code vector
package pkt_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int ERR_DUP_SOP = 0;
  localparam int ERR_LEN     = 1;
  localparam int ERR_DATA    = 2;
  localparam int ERR_TIMEOUT = 3;
  localparam int ERR_W       = 4;

endpackage

// File: rtl/pkt_rx_sat_cnt.sv
// pkt_rx_sat_cnt: saturating up-counter.
//   clk, rst : clock, asynchronous active-high reset (q -> 0)
//   clr      : restart from zero this cycle
//   inc      : amount to add; with clr set the counter loads inc
//   q        : count value, sticks at all-ones instead of wrapping
module pkt_rx_sat_cnt #(
  parameter int W     = 8,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     q
);

  // One guard bit above the count catches the carry that means "saturate".
  logic [W:0] base;
  logic [W:0] sum;

  always_comb begin
    base = clr ? '0 : {1'b0, q};
    sum  = base + (W+1)'(inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/pkt_rx_chk.sv
// pkt_rx_chk: receive-side checker for the sop/eop/vld byte stream leaving
// the packet FIFO. Every beat is consumed; there is no backpressure.
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   din, din_vld         : stream data and beat valid
//   din_sop, din_eop     : first / last beat markers (ignored when !din_vld)
//   pkt_done             : one-cycle pulse, a packet has closed
//   pkt_ok               : packet closed without error (valid with pkt_done)
//   err_code             : {timeout, data, len, dup_sop} of the closed packet
//   last_len             : beat count of the closed packet
//   pkt_cnt              : packets closed, saturating
//   err_cnt              : bad packets plus orphan beats, saturating
//   orphan               : one-cycle pulse, non-sop beat arrived while IDLE
//
// Build option: define PKT_RX_TIMEOUT_EN to close a packet with the timeout
// bit after TIMEOUT consecutive idle cycles inside it. Without it
// err_code[3] is always 0.
module pkt_rx_chk
  import pkt_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16,
  parameter int EXP_LEN = 999,
  parameter int END_VAL = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  output logic              pkt_done,
  output logic              pkt_ok,
  output logic [ERR_W-1:0]  err_code,
  output logic [LEN_W-1:0]  last_len,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              orphan
);

  localparam logic [LEN_W-1:0]  EXP_LEN_V = LEN_W'(EXP_LEN);
  localparam logic [LEN_W-1:0]  ONE_LEN   = LEN_W'(1);
  localparam logic [DATA_W-1:0] END_V     = DATA_W'(END_VAL);
  localparam logic [DATA_W-1:0] FIRST_V   = DATA_W'(1);
  localparam logic              LEN1_BAD  = (EXP_LEN != 1);

  if (EXP_LEN < 1 || TIMEOUT < 1) begin : g_param_check
    $error("pkt_rx_chk: EXP_LEN and TIMEOUT must be at least 1");
  end

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   beat_cnt, beat_cnt_inc;
  logic               cnt_clr, cnt_inc;
  logic               data_err, data_err_nxt;
  logic               pend, pend_nxt;
  logic               pend_data, pend_data_nxt;
  logic               close_now, orphan_now, timeout_hit;
  logic [ERR_W-1:0]   close_code;
  logic [LEN_W-1:0]   close_len;
  logic [1:0]         err_inc;

  pkt_rx_sat_cnt #(.W(LEN_W), .INC_W(1)) u_beat_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (beat_cnt)
  );

  // Beat index of the incoming beat; stays pinned once the counter saturates.
  assign beat_cnt_inc = (&beat_cnt) ? beat_cnt : beat_cnt + ONE_LEN;

`ifdef PKT_RX_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT + 1);
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_idle;

  // Counts consecutive idle cycles inside a packet; any beat, leaving BUSY
  // or the timeout itself restarts it from zero.
  assign gap_idle    = (state == BUSY) && !din_vld;
  assign timeout_hit = gap_idle && (gap_cnt == GAP_W'(TIMEOUT - 1));

  pkt_rx_sat_cnt #(.W(GAP_W), .INC_W(1)) u_gap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!gap_idle || timeout_hit),
    .inc (gap_idle && !timeout_hit),
    .q   (gap_cnt)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // A sop+eop beat that arrives while a packet is open closes the old packet
  // this cycle; the single-beat packet it opens is parked in pend and closes
  // one cycle later so pkt_done never has to report two packets at once.
  always_comb begin
    state_nxt     = state;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    data_err_nxt  = data_err;
    pend_nxt      = 1'b0;
    pend_data_nxt = 1'b0;
    close_now     = 1'b0;
    close_code    = '0;
    close_len     = '0;
    orphan_now    = 1'b0;

    case (state)
      IDLE: begin
        if (pend) begin
          close_now           = 1'b1;
          close_code[ERR_DATA] = pend_data;
          close_code[ERR_LEN]  = LEN1_BAD;
          close_len           = ONE_LEN;
        end
        if (din_vld) begin
          if (!din_sop) begin
            orphan_now = 1'b1;
          end else if (!din_eop) begin
            state_nxt    = BUSY;
            cnt_clr      = 1'b1;
            cnt_inc      = 1'b1;
            data_err_nxt = (din != FIRST_V);
          end else if (pend) begin
            pend_nxt      = 1'b1;
            pend_data_nxt = (din != END_V);
          end else begin
            close_now            = 1'b1;
            close_code[ERR_DATA] = (din != END_V);
            close_code[ERR_LEN]  = LEN1_BAD;
            close_len            = ONE_LEN;
          end
        end
      end

      BUSY: begin
        if (din_vld && din_sop) begin
          close_now               = 1'b1;
          close_code[ERR_DUP_SOP] = 1'b1;
          close_code[ERR_DATA]    = data_err;
          close_code[ERR_LEN]     = (beat_cnt != EXP_LEN_V) || (&beat_cnt);
          close_len               = beat_cnt;
          cnt_clr                 = 1'b1;
          if (din_eop) begin
            state_nxt     = IDLE;
            pend_nxt      = 1'b1;
            pend_data_nxt = (din != END_V);
          end else begin
            cnt_inc      = 1'b1;
            data_err_nxt = (din != FIRST_V);
          end
        end else if (din_vld) begin
          if (din_eop) begin
            close_now            = 1'b1;
            close_code[ERR_DATA] = data_err || (din != END_V);
            close_code[ERR_LEN]  = (beat_cnt_inc != EXP_LEN_V) || (&beat_cnt_inc);
            close_len            = beat_cnt_inc;
            state_nxt            = IDLE;
            cnt_clr              = 1'b1;
          end else begin
            cnt_inc      = 1'b1;
            data_err_nxt = data_err || (din != DATA_W'(beat_cnt_inc));
          end
        end else if (timeout_hit) begin
          close_now               = 1'b1;
          close_code[ERR_TIMEOUT] = 1'b1;
          close_code[ERR_DATA]    = data_err;
          close_code[ERR_LEN]     = (beat_cnt != EXP_LEN_V) || (&beat_cnt);
          close_len               = beat_cnt;
          state_nxt               = IDLE;
          cnt_clr                 = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_err  <= 1'b0;
      pend      <= 1'b0;
      pend_data <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
      err_code  <= '0;
      last_len  <= '0;
      orphan    <= 1'b0;
    end else begin
      state     <= state_nxt;
      data_err  <= data_err_nxt;
      pend      <= pend_nxt;
      pend_data <= pend_data_nxt;
      pkt_done  <= close_now;
      orphan    <= orphan_now;
      if (close_now) begin
        pkt_ok   <= (close_code == '0);
        err_code <= close_code;
        last_len <= close_len;
      end
    end
  end

  // A bad close and an orphan can land in the same cycle, so err_cnt may
  // need to advance by two.
  assign err_inc = 2'(close_now && (close_code != '0)) + 2'(orphan_now);

  pkt_rx_sat_cnt #(.W(CNT_W), .INC_W(1)) u_pkt_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (close_now),
    .q   (pkt_cnt)
  );

  pkt_rx_sat_cnt #(.W(CNT_W), .INC_W(2)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (err_inc),
    .q   (err_cnt)
  );

endmodule

// File: tb/tb_pkt_rx_chk.sv
// tb_pkt_rx_chk: bench for pkt_rx_chk. dut_a uses EXP_LEN=999 and is
// compared every cycle against a transaction-level reference model;
// dut_b uses EXP_LEN=1 and is driven by a short table of vectors.
module tb_pkt_rx_chk;

  localparam int EXP  = 999;
  localparam int ENDV = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;

  logic        a_done, a_ok, a_orphan, b_done, b_ok, b_orphan;
  logic [3:0]  a_code, b_code;
  logic [15:0] a_len, a_pcnt, a_ecnt, b_len, b_pcnt, b_ecnt;

  always #5 clk = ~clk;

  pkt_rx_chk #(.EXP_LEN(EXP)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .pkt_done(a_done), .pkt_ok(a_ok), .err_code(a_code),
    .last_len(a_len), .pkt_cnt(a_pcnt), .err_cnt(a_ecnt), .orphan(a_orphan)
  );

  pkt_rx_chk #(.EXP_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .pkt_done(b_done), .pkt_ok(b_ok), .err_code(b_code),
    .last_len(b_len), .pkt_cnt(b_pcnt), .err_cnt(b_ecnt), .orphan(b_orphan)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (dut_a) ----------------
  typedef struct { int step; bit ok; logic [3:0] code; int len; } close_t;
  typedef struct { logic ok; logic [3:0] code; logic [15:0] len; } rec_t;

  close_t exp_q[$];
  rec_t   dut_log[$];
  bit     model_on = 1'b1;
  bit     m_busy, m_bad;
  int     m_cnt, m_last_step, m_orphan_step, m_pkt, m_err;
  int     step_no = 0;
  int     done_seen = 0;

  task automatic model_reset();
    exp_q.delete();
    m_busy = 0; m_bad = 0; m_cnt = 0;
    m_last_step = -1; m_orphan_step = -1; m_pkt = 0; m_err = 0;
  endtask

  // Closes are reported one cycle after their beat, at most one per cycle,
  // in order; a second close from the same beat slips to the next free cycle.
  function automatic void push_close(int k, int len, bit bad, bit dup);
    close_t c;
    c.len  = len;
    c.code = {1'b0, bad, (len != EXP) || (len >= 65535), dup};
    c.ok   = (c.code == 4'd0);
    c.step = (k + 1 > m_last_step + 1) ? k + 1 : m_last_step + 1;
    m_last_step = c.step;
    exp_q.push_back(c);
  endfunction

  function automatic void model_beat(bit s, bit e, logic [7:0] d, int k);
    if (!m_busy) begin
      if (!s) m_orphan_step = k + 1;
      else if (e) push_close(k, 1, d != 8'(ENDV), 0);
      else begin m_busy = 1; m_cnt = 1; m_bad = (d != 8'd1); end
    end else if (s) begin
      push_close(k, m_cnt, m_bad, 1);
      if (e) begin m_busy = 0; push_close(k, 1, d != 8'(ENDV), 0); end
      else begin m_cnt = 1; m_bad = (d != 8'd1); end
    end else begin
      if (m_cnt < 65535) m_cnt++;
      if (e) begin m_busy = 0; push_close(k, m_cnt, m_bad || (d != 8'(ENDV)), 0); end
      else m_bad = m_bad || (d != 8'(m_cnt));
    end
  endfunction

  task automatic model_check();
    bit     exp_done;
    bit     exp_orph;
    close_t c;
    exp_done = 0;
    exp_orph = (m_orphan_step == step_no);
    if (exp_q.size() > 0 && exp_q[0].step == step_no) begin
      exp_done = 1;
      c = exp_q.pop_front();
      m_pkt++;
      if (!c.ok) m_err++;
    end
    if (exp_orph) m_err++;
    checkOutput($sformatf("a_pkt_done@%0d", step_no), a_done, exp_done);
    if (exp_done) begin
      checkOutput($sformatf("a_pkt_ok@%0d", step_no), a_ok, c.ok);
      checkOutput($sformatf("a_err_code@%0d", step_no), a_code, c.code);
      checkOutput($sformatf("a_last_len@%0d", step_no), a_len, c.len);
    end
    checkOutput($sformatf("a_orphan@%0d", step_no), a_orphan, exp_orph);
    checkOutput($sformatf("a_pkt_cnt@%0d", step_no), a_pcnt, m_pkt);
    checkOutput($sformatf("a_err_cnt@%0d", step_no), a_ecnt, m_err);
  endtask

  // One cycle: check what the previous edge produced, then drive a new beat.
  task automatic applyStimulus(input bit v, input bit s, input bit e, input logic [7:0] d);
    rec_t r;
    @(negedge clk);
    if (a_done) begin
      r.ok = a_ok; r.code = a_code; r.len = a_len;
      dut_log.push_back(r);
      done_seen++;
    end
    if (model_on) model_check();
    din_vld = v; din_sop = s; din_eop = e; din = d;
    if (model_on && v) model_beat(s, e, d, step_no);
    step_no++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 8'h00);
  endtask

  task automatic sendPacket(input int len, input int bad_beat, input bit do_eop,
                            input int gap_pct, input logic [7:0] bad_xor);
    logic [7:0] d;
    for (int i = 1; i <= len; i++) begin
      d = (i == len && do_eop) ? 8'(ENDV) : 8'(i);
      if (i == bad_beat) d = d ^ bad_xor;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) applyStimulus(0, 0, 0, 8'h00);
      applyStimulus(1, i == 1, do_eop && (i == len), d);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1; din_vld = 0; din_sop = 0; din_eop = 0; din = '0;
    @(negedge clk);
    checkOutput("reset_a_outputs", {a_done, a_ok, a_code, a_len, a_pcnt, a_ecnt, a_orphan}, 64'd0);
    checkOutput("reset_b_outputs", {b_done, b_ok, b_code, b_len, b_pcnt, b_ecnt, b_orphan}, 64'd0);
    rst = 0;
    model_reset();
    model_on = 1;
    step_no = 0;
    dut_log.delete();
  endtask

  // ---------------- dut_b vector table ----------------
  typedef struct {
    logic v, s, e; logic [7:0] d;
    logic done, ok; logic [3:0] code; logic [15:0] len;
    logic orph; logic [15:0] pcnt, ecnt;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int good;
    int kind, len, bad;

    tbl[0] = '{1'b1,1'b0,1'b1,8'd1, 1'b0,1'b0,4'h0,16'd0, 1'b1,16'd0,16'd1};
    tbl[1] = '{1'b1,1'b1,1'b1,8'd1, 1'b1,1'b1,4'h0,16'd1, 1'b0,16'd1,16'd1};
    tbl[2] = '{1'b1,1'b1,1'b1,8'd7, 1'b1,1'b0,4'h4,16'd1, 1'b0,16'd2,16'd2};
    tbl[3] = '{1'b1,1'b1,1'b0,8'd1, 1'b0,1'b0,4'h0,16'd0, 1'b0,16'd2,16'd2};
    tbl[4] = '{1'b1,1'b0,1'b1,8'd1, 1'b1,1'b0,4'h2,16'd2, 1'b0,16'd3,16'd3};
    tbl[5] = '{1'b1,1'b1,1'b0,8'd1, 1'b0,1'b0,4'h0,16'd0, 1'b0,16'd3,16'd3};
    tbl[6] = '{1'b1,1'b1,1'b1,8'd9, 1'b1,1'b0,4'h1,16'd1, 1'b0,16'd4,16'd4};
    tbl[7] = '{1'b1,1'b0,1'b0,8'd0, 1'b1,1'b0,4'h4,16'd1, 1'b1,16'd5,16'd6};
    tbl[8] = '{1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,4'h0,16'd0, 1'b0,16'd5,16'd6};

    // Ten good 999-beat packets with 20-cycle gaps
    doReset();
    for (int p = 0; p < 10; p++) begin
      sendPacket(999, 0, 1, 0, 8'h00);
      idle(20);
    end
    good = 0;
    foreach (dut_log[i]) if (dut_log[i].ok && dut_log[i].len == 16'd999) good++;
    checkOutput("t1_good_pkts", good, 10);
    checkOutput("t1_pkt_cnt", a_pcnt, 10);
    checkOutput("t1_err_cnt", a_ecnt, 0);

    // Short packet: length error only
    doReset();
    sendPacket(500, 0, 1, 0, 8'h00);
    idle(3);
    checkOutput("t2_closes", dut_log.size(), 1);
    checkOutput("t2_pkt_ok", dut_log[0].ok, 0);
    checkOutput("t2_err_code", dut_log[0].code, 4'b0010);
    checkOutput("t2_last_len", dut_log[0].len, 500);
    checkOutput("t2_err_cnt", a_ecnt, 1);

    // Beat 300 carries 0x00 instead of 0x2C
    doReset();
    sendPacket(999, 300, 1, 0, 8'h2C);
    idle(3);
    checkOutput("t3_err_code", dut_log[0].code, 4'b0100);
    checkOutput("t3_last_len", dut_log[0].len, 999);

    // sop reasserted at beat 400, then a good packet
    doReset();
    sendPacket(399, 0, 0, 0, 8'h00);
    sendPacket(999, 0, 1, 0, 8'h00);
    idle(3);
    checkOutput("t4_closes", dut_log.size(), 2);
    checkOutput("t4_first_code", dut_log[0].code, 4'b0011);
    checkOutput("t4_first_len", dut_log[0].len, 399);
    checkOutput("t4_second_ok", dut_log[1].ok, 1);
    checkOutput("t4_pkt_cnt", a_pcnt, 2);

    // dut_b table: orphans, single-beat packets, dup sop with eop
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
      @(posedge clk);
      #1;
      checkOutput($sformatf("b_row%0d_done", i), b_done, tbl[i].done);
      if (tbl[i].done) begin
        checkOutput($sformatf("b_row%0d_ok", i), b_ok, tbl[i].ok);
        checkOutput($sformatf("b_row%0d_code", i), b_code, tbl[i].code);
        checkOutput($sformatf("b_row%0d_len", i), b_len, tbl[i].len);
      end
      checkOutput($sformatf("b_row%0d_orphan", i), b_orphan, tbl[i].orph);
      checkOutput($sformatf("b_row%0d_pkt_cnt", i), b_pcnt, tbl[i].pcnt);
      checkOutput($sformatf("b_row%0d_err_cnt", i), b_ecnt, tbl[i].ecnt);
    end

`ifdef PKT_RX_TIMEOUT_EN
    // 65-cycle gap after beat 10 trips the timeout
    doReset();
    model_on = 0;
    sendPacket(10, 0, 0, 0, 8'h00);
    idle(68);
    checkOutput("t6_closes", dut_log.size(), 1);
    checkOutput("t6_err_code", dut_log[0].code, 4'b1010);
    checkOutput("t6_last_len", dut_log[0].len, 10);
`endif

    // Reset in the middle of a packet
    doReset();
    sendPacket(5, 0, 1, 0, 8'h00);
    idle(2);
    done_seen = 0;
    sendPacket(99, 0, 0, 0, 8'h00);
    @(negedge clk);
    if (a_done) done_seen++;
    rst = 1; din_vld = 1; din_sop = 0; din_eop = 0; din = 8'd100;
    @(negedge clk);
    if (a_done) done_seen++;
    checkOutput("t7_outputs_zero", {a_done, a_ok, a_code, a_len, a_pcnt, a_ecnt, a_orphan}, 64'd0);
    rst = 0; din_vld = 0;
    model_reset();
    step_no = 0;
    idle(5);
    applyStimulus(1, 0, 0, 8'd101);
    idle(3);
    checkOutput("t7_no_pkt_done", done_seen, 0);

    // Randomized traffic against the model
    doReset();
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(9);
      case (kind)
        0: applyStimulus(1, 0, 1'($urandom_range(1)), 8'($urandom));
        1: sendPacket(1, $urandom_range(1), 1, 0, 8'h5A);
        2: begin
          sendPacket($urandom_range(1, 50), 0, 0, 10, 8'h00);
          if ($urandom_range(1) == 1)
            applyStimulus(1, 1, 1, ($urandom_range(1) == 1) ? 8'(ENDV) : 8'h33);
        end
        3, 4, 5: begin
          len = $urandom_range(2, 40);
          bad = ($urandom_range(2) == 0) ? $urandom_range(1, len) : 0;
          sendPacket(len, bad, 1, 10, 8'h5A);
        end
        default: begin
          len = $urandom_range(995, 1003);
          bad = ($urandom_range(2) == 0) ? $urandom_range(1, len) : 0;
          sendPacket(len, bad, 1, 10, 8'h5A);
        end
      endcase
      idle($urandom_range(0, 3));
    end
    idle(5);
    checkOutput("rand_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
